pwm_halfbridge_gen: RTL and testbench

Complementary PWM source for one e-bike motor-phase half-bridge. It turns a duty command into the raw high-side/low-side gate requests that the downstream dead-time inserter consumes, one instance per phase. Duty updates use a valid/ready handshake and are double-buffered so that they only take effect at a period boundary. Duty is clamped so that no pulse is shorter than the downstream dead time.

---
 rtl/pwm_halfbridge_gen.sv | 133 +++++++++++++
 tb/tb_pwm_halfbridge_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_halfbridge_gen.sv
// ============================================================================
// pwm_halfbridge_gen : double-buffered complementary PWM for one half-bridge
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_halfbridge_gen #(
  parameter int WIDTH     = 11,
  parameter int MIN_PULSE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_vld,
  output logic             duty_rdy,
  output logic             high_drv,
  output logic             low_drv,
  output logic             period_start,
  output logic             running
);

  localparam logic [WIDTH:0] C_FULL   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] C_LO_LIM = (WIDTH+1)'(MIN_PULSE);
  localparam logic [WIDTH:0] C_HI_LIM = C_FULL - C_LO_LIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [WIDTH:0]   act_q, act_d;
  logic             high_drv_q, high_drv_d;
  logic             low_drv_q, low_drv_d;
  logic             period_start_q, period_start_d;
  logic             wrap;
  logic             hi;

  // Pulses shorter than the downstream dead time collapse to a solid level.
  function automatic logic [WIDTH:0] clamp(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] ext;
    ext = {1'b0, d};
    if (ext < C_LO_LIM)
      clamp = '0;
    else if (ext > C_HI_LIM)
      clamp = C_FULL;
    else
      clamp = ext;
  endfunction

  assign wrap = (cnt_q == '1);
  assign hi   = ({1'b0, cnt_q} < act_q);

  always_comb begin
    cnt_d          = cnt_q + WIDTH'(1);
    pend_d         = pend_q;
    pend_full_d    = pend_full_q;
    act_d          = act_q;
    period_start_d = (cnt_q == '0);

    if (wrap && pend_full_q) begin
      act_d       = clamp(pend_q);
      pend_full_d = 1'b0;
    end
    // A capture on the wrap edge into an empty buffer waits for the next wrap.
    if (duty_vld && !pend_full_q) begin
      pend_d      = duty;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    high_drv_d = 1'b0;
    low_drv_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)
          state_d = ST_IDLE;
        else if (wrap)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          high_drv_d = hi;
          low_drv_d  = ~hi;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pend_q         <= '0;
      pend_full_q    <= 1'b0;
      act_q          <= '0;
      high_drv_q     <= 1'b0;
      low_drv_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      pend_full_q    <= pend_full_d;
      act_q          <= act_d;
      high_drv_q     <= high_drv_d;
      low_drv_q      <= low_drv_d;
      period_start_q <= period_start_d;
    end
  end

  assign duty_rdy     = ~pend_full_q;
  assign high_drv     = high_drv_q;
  assign low_drv      = low_drv_q;
  assign period_start = period_start_q;
  assign running      = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pwm_halfbridge_gen.sv
// ============================================================================
// tb_pwm_halfbridge_gen : directed scoreboard bench for pwm_halfbridge_gen
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_halfbridge_gen;

  localparam int W = 11;
  localparam int P = 2048;

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic         enable   = 1'b0;
  logic [W-1:0] duty     = '0;
  logic         duty_vld = 1'b0;
  logic         duty_rdy;
  logic         high_drv;
  logic         low_drv;
  logic         period_start;
  logic         running;

  int n_checks = 0;
  int n_fails  = 0;
  int sb[$];

  pwm_halfbridge_gen #(
    .WIDTH     (W),
    .MIN_PULSE (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty         (duty),
    .duty_vld     (duty_vld),
    .duty_rdy     (duty_rdy),
    .high_drv     (high_drv),
    .low_drv      (low_drv),
    .period_start (period_start),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_pstart(input string tag);
    int k = 0;
    while (period_start !== 1'b1 && k < 4200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_pstart"}, 32'(period_start), 1);
  endtask

  task automatic send_duty(input logic [W-1:0] d);
    logic acc = 1'b0;
    int   k   = 0;
    duty     = d;
    duty_vld = 1'b1;
    while (!acc && k < 4200) begin
      acc = (duty_rdy === 1'b1);
      @(negedge clk);
      k++;
    end
    duty_vld = 1'b0;
    check("hs_accept", 32'(acc), 1);
  endtask

  // Measures one full period starting at a period_start sample and
  // compares against the next scoreboard entry (expected high-side cycles).
  task automatic run_period(input string tag);
    int exp_hi;
    int nh = 0;
    int nl = 0;
    int nb = 0;
    wait_pstart(tag);
    if (sb.size() == 0) exp_hi = -1;
    else exp_hi = sb.pop_front();
    for (int i = 0; i < P; i++) begin
      if (high_drv === 1'b1) nh++;
      if (low_drv === 1'b1) nl++;
      if (high_drv === 1'b1 && low_drv === 1'b1) nb++;
      @(negedge clk);
    end
    check({tag, "_hi"}, nh, exp_hi);
    check({tag, "_lo"}, nl, P - exp_hi);
    check({tag, "_both"}, nb, 0);
  endtask

  initial begin
    int dv[5];
    int ev[5];
    int k;
    int viol;

    dv = '{10, 2030, 32, 31, 2016};
    ev = '{0, 2048, 32, 0, 2016};

    repeat (3) @(negedge clk);
    check("rst_high", 32'(high_drv), 0);
    check("rst_low", 32'(low_drv), 0);
    check("rst_pstart", 32'(period_start), 0);
    check("rst_running", 32'(running), 0);
    check("rst_rdy", 32'(duty_rdy), 1);

    // Release, enable and load 50% in the first cycle.
    rst    = 1'b0;
    enable = 1'b1;
    send_duty(11'd1024);
    check("armed_pstart", 32'(period_start), 1);
    check("armed_high", 32'(high_drv), 0);
    check("armed_low", 32'(low_drv), 0);
    check("armed_running", 32'(running), 0);
    @(negedge clk);
    sb.push_back(1024);
    run_period("p50");
    check("p50_running", 32'(running), 1);

    // Clamp boundaries.
    for (int i = 0; i < 5; i++) begin
      send_duty(W'(dv[i]));
      sb.push_back(ev[i]);
      run_period($sformatf("clamp%0d", dv[i]));
    end

    // Back-pressure: second value waits until the wrap frees the buffer.
    send_duty(11'd500);
    duty     = 11'd1500;
    duty_vld = 1'b1;
    k = 0;
    while (duty_rdy !== 1'b1 && k < 4200) begin
      @(negedge clk);
      k++;
    end
    check("bp_rdy_low_cycles", k, 2046);
    @(negedge clk);
    duty_vld = 1'b0;
    check("bp_rdy_after_cap", 32'(duty_rdy), 0);
    sb.push_back(500);
    sb.push_back(1500);
    run_period("bp500");
    run_period("bp1500");

    // Enable gating.
    send_duty(11'd1024);
    sb.push_back(1024);
    run_period("en_pre");
    repeat (299) @(negedge clk);
    check("en_before_high", 32'(high_drv), 1);
    enable = 1'b0;
    @(negedge clk);
    check("en_off_high", 32'(high_drv), 0);
    check("en_off_low", 32'(low_drv), 0);
    check("en_off_running", 32'(running), 0);
    repeat (399) @(negedge clk);
    check("en_idle_low", 32'(low_drv), 0);
    enable = 1'b1;
    k    = 0;
    viol = 0;
    do begin
      @(negedge clk);
      k++;
      if (period_start !== 1'b1 && (high_drv !== 1'b0 || low_drv !== 1'b0)) viol++;
    end while (period_start !== 1'b1 && k < 4200);
    check("en_wait_cycles", k, 1349);
    check("en_wait_quiet", viol, 0);
    check("en_resume_high", 32'(high_drv), 1);
    sb.push_back(1024);
    run_period("en_resume");

    // Handshake in the wrap cycle with an empty buffer.
    repeat (2046) @(negedge clk);
    check("wrap_rdy", 32'(duty_rdy), 1);
    duty     = 11'd300;
    duty_vld = 1'b1;
    @(negedge clk);
    duty_vld = 1'b0;
    check("wrap_captured", 32'(duty_rdy), 0);
    @(negedge clk);
    sb.push_back(1024);
    sb.push_back(300);
    run_period("wrap_old");
    run_period("wrap_new");

    // Asynchronous reset in the middle of a high pulse with a pending value.
    send_duty(11'd700);
    repeat (100) @(negedge clk);
    check("arst_pre_high", 32'(high_drv), 1);
    check("arst_pre_rdy", 32'(duty_rdy), 0);
    #2 rst = 1'b1;
    #1;
    check("arst_high", 32'(high_drv), 0);
    check("arst_low", 32'(low_drv), 0);
    check("arst_running", 32'(running), 0);
    check("arst_pstart", 32'(period_start), 0);
    check("arst_rdy", 32'(duty_rdy), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
